// File: rtl/m_cal_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_cal_pkg
// Shared types and helpers for the calibration sum engine.
// Revision: 1.0
// ---------------------------------------------------------------------------
package m_cal_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cal_state_e;

  // Accumulator width: wide enough that CGES full-scale samples never overflow
  function automatic int acc_width(input int dw, input int cges);
    return dw + $clog2(cges);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_cal_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_cal_if
// Controller / sample-memory bus for the calibration sum engine.
// master = controller + memory side, slave = engine side.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface m_cal_if #(
  parameter int CGES = 7,
  parameter int DW   = 16
);
  import m_cal_pkg::*;

  localparam int AW = $clog2(CGES);
  localparam int RW = acc_width(DW, CGES);

  logic          cal;
  logic [AW-1:0] addr;
  logic [DW-1:0] rd_data;
  logic          fin;
  logic [RW-1:0] result;
  logic          res_valid;
  logic          busy;
  logic          ovf;

  modport master (
    output cal, rd_data,
    input  addr, fin, result, res_valid, busy, ovf
  );

  modport slave (
    input  cal, rd_data,
    output addr, fin, result, res_valid, busy, ovf
  );

endinterface
`default_nettype wire

// File: rtl/m_cal_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_cal_acc
// Sample accumulator with a one-bit data-valid pipeline that follows the
// registered memory latency, plus the result capture register.
// Optional macro M_CAL_SAT_EN: clamp at 2^DW-1 and raise sticky ovf.
// Revision: 1.0
// ---------------------------------------------------------------------------
module m_cal_acc
  import m_cal_pkg::*;
#(
  parameter int CGES = 7,
  parameter int DW   = 16
) (
  input  wire logic                            clk,
  input  wire logic                            reset_n,
  input  wire logic                            clr_i,     // accepted cal: start clean
  input  wire logic                            vld_i,     // an address is presented this cycle
  input  wire logic                            cap_i,     // latch final sum into result
  input  wire logic [DW-1:0]                   rd_data_i,
  output logic      [acc_width(DW, CGES)-1:0]  result_o,
  output logic                                 ovf_o
);

  localparam int AW = $clog2(CGES);
  localparam int RW = acc_width(DW, CGES);

  logic          vld_q;
  logic [RW-1:0] acc_q;
  logic [RW-1:0] acc_d;
  logic [RW-1:0] result_q;
  logic [RW-1:0] add_w;
  logic [RW-1:0] sum_w;
  logic          clamp_w;

  // Only data whose address was presented one cycle earlier is summed
  assign add_w = vld_q ? {{AW{1'b0}}, rd_data_i} : '0;
  assign sum_w = acc_q + add_w;

`ifdef M_CAL_SAT_EN
  localparam logic [RW-1:0] SAT_MAX = {{AW{1'b0}}, {DW{1'b1}}};

  logic ovf_q;

  assign clamp_w = (sum_w > SAT_MAX);
  assign acc_d   = clamp_w ? SAT_MAX : sum_w;
  assign ovf_o   = ovf_q;

  // Sticky overflow: cleared only when a new calculation is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf_q <= 1'b0;
    else if (clr_i)   ovf_q <= 1'b0;
    else if (clamp_w) ovf_q <= 1'b1;
  end
`else
  assign clamp_w = 1'b0;
  assign acc_d   = sum_w;
  assign ovf_o   = clamp_w;
`endif

  // Valid pipeline, running sum and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      vld_q <= vld_i;
      if (clr_i) acc_q <= '0;
      else       acc_q <= acc_d;
      if (cap_i) result_q <= acc_d;
    end
  end

  assign result_o = result_q;

endmodule
`default_nettype wire

// File: rtl/m_cal_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_cal_engine
// Reads CGES samples from a registered memory and sums them on a level
// cal request; pulses fin and holds result/res_valid until the next accept.
// Optional macro M_CAL_SAT_EN (in m_cal_acc): saturating sum with ovf flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
module m_cal_engine
  import m_cal_pkg::*;
#(
  parameter int CGES = 7,
  parameter int DW   = 16
) (
  input  wire logic clk,
  input  wire logic reset_n,
  m_cal_if.slave    bus
);

  localparam int AW = $clog2(CGES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CGES - 1);

  cal_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          fin_q, fin_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic          acc_clr, acc_vld, acc_cap;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fin_q       <= fin_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next state; cal low anywhere before DONE abandons the calculation
  always_comb begin
    state_d     = state_q;
    addr_d      = '0;
    fin_d       = 1'b0;
    res_valid_d = res_valid_q;
    acc_clr     = 1'b0;
    acc_cap     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cal) begin
          state_d     = ST_FETCH;
          res_valid_d = 1'b0;
          acc_clr     = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!bus.cal)                state_d = ST_IDLE;
        else if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                          addr_d  = addr_q + AW'(1);
      end
      ST_DRAIN: begin
        if (!bus.cal) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
          fin_d       = 1'b1;
          res_valid_d = 1'b1;
          acc_cap     = 1'b1;
        end
      end
      ST_DONE: begin
        if (!bus.cal) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    acc_vld = (state_q == ST_FETCH) && bus.cal;
  end

  m_cal_acc #(
    .CGES (CGES),
    .DW   (DW)
  ) u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (acc_clr),
    .vld_i     (acc_vld),
    .cap_i     (acc_cap),
    .rd_data_i (bus.rd_data),
    .result_o  (bus.result),
    .ovf_o     (bus.ovf)
  );

  assign bus.addr      = addr_q;
  assign bus.fin       = fin_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;

endmodule
`default_nettype wire
